// File: rtl/logic_unit_pipe.sv
// Single-stage bitwise logic unit with accumulator feedback,
// valid/ready handshake and a saturating transaction counter.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic [WIDTH-1:0]  w_b_eff;
    logic [WIDTH-1:0]  w_res;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_y;
    logic              r_zero;
    logic              r_parity;
    logic [CNT_W-1:0]  r_cnt;

    // in_ready depends only on registered state and out_ready
    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    assign w_b_eff = !acc_en ? b :
                     acc_clr ? '0 : r_acc;

    always_comb begin
        w_res = '0;
        unique case (op)
            3'b000: w_res = a & w_b_eff;
            3'b001: w_res = a | w_b_eff;
            3'b010: w_res = ~(a & w_b_eff);
            3'b011: w_res = ~(a | w_b_eff);
            3'b100: w_res = a ^ w_b_eff;
            3'b101: w_res = ~(a ^ w_b_eff);
            3'b110: w_res = ~a;
            3'b111: w_res = a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_EMPTY: if (w_accept) w_next = S_FULL;
            S_FULL:  if (out_ready && !w_accept) w_next = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        unique case (r_state)
            S_EMPTY: out_valid = 1'b0;
            S_FULL:  out_valid = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y      <= '0;
            r_zero   <= 1'b1;
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_y      <= w_res;
            r_zero   <= (w_res == '0);
            r_parity <= ^w_res;
        end
    end

    // A clear without an accept wipes the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_res;
        end else if (acc_clr) begin
            r_acc <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign y        = r_y;
    assign zero     = r_zero;
    assign parity   = r_parity;
    assign op_count = r_cnt;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-vector bench for logic_unit_pipe (WIDTH=8, CNT_W=4).
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       acc_en = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] y;
    logic       zero;
    logic       parity;
    logic [3:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sweep_exp [8] = '{8'h30, 8'hFC, 8'hCF, 8'h03,
                                  8'hCC, 8'h33, 8'h0F, 8'hF0};

    logic [7:0] chain_a   [4] = '{8'h01, 8'h02, 8'h04, 8'h80};
    logic [7:0] chain_exp [4] = '{8'h01, 8'h03, 8'h07, 8'h87};

    logic [3:0] sat_exp;

    logic_unit_pipe #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .acc_en   (acc_en),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .zero     (zero),
        .parity   (parity),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_zero", zero, 1);
        check("rst_parity", parity, 0);
        check("rst_count", op_count, 0);
        check("rst_in_ready", in_ready, 1);

        // op sweep, first accept on first edge after release
        in_valid = 1'b1;
        a = 8'hF0;
        b = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick();
            check($sformatf("sweep_y%0d", i), y, sweep_exp[i]);
            check($sformatf("sweep_v%0d", i), out_valid, 1);
        end
        in_valid = 1'b0;
        check("sweep_count", op_count, 8);
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_y_hold", y, 8'hF0);

        // backpressure
        do_reset();
        in_valid  = 1'b1;
        a         = 8'hAA;
        b         = 8'hFF;
        op        = 3'b000;
        out_ready = 1'b0;
        tick();
        a  = 8'h11;
        op = 3'b001;
        for (int i = 0; i < 3; i++) begin
            check("bp_y", y, 8'hAA);
            check("bp_parity", parity, 0);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_count", op_count, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_next_y", y, 8'hFF);
        check("bp_next_count", op_count, 2);

        // accumulator chain
        do_reset();
        in_valid = 1'b1;
        acc_en   = 1'b1;
        op       = 3'b001;
        b        = 8'h55;
        for (int i = 0; i < 4; i++) begin
            acc_clr = (i == 0);
            a = chain_a[i];
            tick();
            check($sformatf("acc_y%0d", i), y, chain_exp[i]);
        end
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        tick();
        acc_clr  = 1'b0;
        in_valid = 1'b1;
        a = 8'h10;
        tick();
        check("acc_after_clr", y, 8'h10);

        // flags
        acc_en = 1'b0;
        a  = 8'h55;
        b  = 8'h55;
        op = 3'b100;
        tick();
        check("flag_xor_y", y, 8'h00);
        check("flag_xor_zero", zero, 1);
        check("flag_xor_par", parity, 0);
        a  = 8'h07;
        op = 3'b111;
        tick();
        in_valid = 1'b0;
        check("flag_pass_y", y, 8'h07);
        check("flag_pass_zero", zero, 0);
        check("flag_pass_par", parity, 1);

        // counter saturation
        do_reset();
        in_valid = 1'b1;
        op = 3'b111;
        for (int k = 1; k <= 20; k++) begin
            a = 8'(k);
            tick();
            sat_exp = (k >= 15) ? 4'hF : 4'(k);
            check($sformatf("sat_%0d", k), op_count, sat_exp);
        end
        in_valid = 1'b0;

        // async reset mid-transaction
        do_reset();
        in_valid  = 1'b1;
        a         = 8'hC3;
        op        = 3'b111;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("ar_pre_y", y, 8'hC3);
        check("ar_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_y", y, 0);
        check("ar_zero", zero, 1);
        check("ar_count", op_count, 0);
        check("ar_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_out", out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
